gpio_controller: RTL and testbench

Memory-mapped GPIO controller. It generalises the 16-pin GPIO port to a parametrised pin count and base address, and adds:
- per-pin input debouncing
- atomic set/clear/toggle of output bits
- rising/falling edge detection with a sticky interrupt status and a single level interrupt line
It sits on the shared data bus beside the other memory-mapped peripherals and drives the FPGA GPIO pins.

---
 rtl/gpio_controller.sv | 144 ++++++++++++++
 tb/tb_gpio_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_controller.sv
// gpio_controller: memory-mapped GPIO port with synchronised, debounced inputs,
// atomic set/clear/toggle of outputs and a sticky edge-capture interrupt.
module gpio_controller #(
    parameter int unsigned WIDTH           = 16,
    parameter logic [31:0] BASE_ADDR       = 32'h4034,
    parameter int unsigned SYNC_DEPTH      = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [31:0]      data_bus_data,
    input  logic [31:0]      data_bus_addr,
    input  logic [1:0]       data_bus_mode,
    inout  wire  [WIDTH-1:0] gpio_pins,
    output logic             irq
);

    // Counter saturates at DEBOUNCE_CYCLES-1; 0 or 1 collapses to "accept at once".
    localparam int unsigned CntMax = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;

    localparam logic [3:0] IdxDir    = 4'd0;
    localparam logic [3:0] IdxOut    = 4'd1;
    localparam logic [3:0] IdxIn     = 4'd2;
    localparam logic [3:0] IdxSet    = 4'd3;
    localparam logic [3:0] IdxClr    = 4'd4;
    localparam logic [3:0] IdxTgl    = 4'd5;
    localparam logic [3:0] IdxRise   = 4'd6;
    localparam logic [3:0] IdxFall   = 4'd7;
    localparam logic [3:0] IdxStatus = 4'd8;

    logic [WIDTH-1:0] dir_q, out_q, rise_en_q, fall_en_q, status_q;
    logic [WIDTH-1:0] stable_q, prev_q;
    logic [WIDTH-1:0] sync_q [SYNC_DEPTH];
    logic [CntW-1:0]  cnt_q  [WIDTH];

    logic [31:0]      offset;
    logic             hit, rd_en, wr_en;
    logic [3:0]       idx;
    logic [31:0]      rdata;
    logic [WIDTH-1:0] wdata, sync, rise, fall, w1c;
    logic             unused_bus;

    // Addresses below BASE_ADDR wrap to huge offsets and fall outside the window.
    assign offset = data_bus_addr - BASE_ADDR;
    assign hit    = (offset <= 32'h20) && (offset[1:0] == 2'b00);
    assign idx    = offset[5:2];
    assign rd_en  = (data_bus_mode == 2'b01) && hit;
    assign wr_en  = (data_bus_mode == 2'b10) && hit;
    assign wdata  = data_bus_data[WIDTH-1:0];
    assign unused_bus = ^data_bus_data;

    // Read mux; write-only registers and bits above WIDTH read as zero.
    always_comb begin
        rdata = '0;
        case (idx)
            IdxDir:    rdata[WIDTH-1:0] = dir_q;
            IdxOut:    rdata[WIDTH-1:0] = out_q;
            IdxIn:     rdata[WIDTH-1:0] = stable_q;
            IdxRise:   rdata[WIDTH-1:0] = rise_en_q;
            IdxFall:   rdata[WIDTH-1:0] = fall_en_q;
            IdxStatus: rdata[WIDTH-1:0] = status_q;
            default:   rdata = '0;
        endcase
    end

    assign data_bus_data = rd_en ? rdata : 32'bz;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign gpio_pins[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    // Control registers written from the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (wr_en) begin
            case (idx)
                IdxDir:  dir_q     <= wdata;
                IdxOut:  out_q     <= wdata;
                IdxSet:  out_q     <= out_q | wdata;
                IdxClr:  out_q     <= out_q & ~wdata;
                IdxTgl:  out_q     <= out_q ^ wdata;
                IdxRise: rise_en_q <= wdata;
                IdxFall: fall_en_q <= wdata;
                default: ;
            endcase
        end
    end

    // Multi-stage synchroniser on the raw pin levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_DEPTH; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= gpio_pins;
            for (int k = 1; k < SYNC_DEPTH; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sync = sync_q[SYNC_DEPTH-1];

    // Per-pin debounce: a difference must persist DEBOUNCE_CYCLES edges to be accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] != stable_q[i]) begin
                    if (cnt_q[i] == CntW'(CntMax)) begin
                        stable_q[i] <= sync[i];
                        cnt_q[i]    <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CntW'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign rise = stable_q & ~prev_q & rise_en_q;
    assign fall = ~stable_q & prev_q & fall_en_q;
    assign w1c  = (wr_en && idx == IdxStatus) ? wdata : '0;

    // Edge capture; a new edge overrides a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q   <= '0;
            status_q <= '0;
        end else begin
            prev_q   <= stable_q;
            status_q <= (status_q & ~w1c) | rise | fall;
        end
    end

    assign irq = |status_q;

endmodule

// File: tb/tb_gpio_controller.sv
// tb_gpio_controller: directed stimulus against a window-based behavioural model,
// checked every cycle, plus hand-computed register and latency expectations.
module tb_gpio_controller;

    localparam int unsigned W    = 16;
    localparam logic [31:0] BASE = 32'h4034;
    localparam int unsigned S    = 3;
    localparam int unsigned D    = 4;
    localparam int unsigned DW   = (D > 1) ? D : 1;
    localparam int unsigned HIST = S + DW;

    localparam logic [31:0] A_DIR  = BASE + 32'h00;
    localparam logic [31:0] A_OUT  = BASE + 32'h04;
    localparam logic [31:0] A_IN   = BASE + 32'h08;
    localparam logic [31:0] A_SET  = BASE + 32'h0C;
    localparam logic [31:0] A_CLR  = BASE + 32'h10;
    localparam logic [31:0] A_TGL  = BASE + 32'h14;
    localparam logic [31:0] A_RISE = BASE + 32'h18;
    localparam logic [31:0] A_FALL = BASE + 32'h1C;
    localparam logic [31:0] A_STAT = BASE + 32'h20;

    logic          clk = 1'b0;
    logic          reset;
    wire  [31:0]   bus;
    logic [31:0]   addr;
    logic [1:0]    mode;
    wire  [W-1:0]  pins;
    logic          irq;

    logic          bus_en    = 1'b0;
    logic [31:0]   bus_wdata = '0;
    logic [W-1:0]  tb_val    = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic [W-1:0] m_dir = '0, m_out = '0, m_re = '0, m_fe = '0, m_status = '0;
    logic [W-1:0] m_in = '0, m_prev = '0;
    logic [W-1:0] hist [HIST];

    always #5 clk = ~clk;

    assign bus = bus_en ? bus_wdata : 32'bz;

    // The bench drives every pin the model says is an input.
    for (genvar i = 0; i < W; i++) begin : g_drv
        assign pins[i] = m_dir[i] ? 1'bz : tb_val[i];
    end

    gpio_controller #(
        .WIDTH(W), .BASE_ADDR(BASE), .SYNC_DEPTH(S), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .data_bus_data(bus), .data_bus_addr(addr),
        .data_bus_mode(mode), .gpio_pins(pins), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Undriven bus: no bit may be a driven 1.
    task automatic chk_nd(input string name, input logic [31:0] act);
        logic one = 1'b0;
        n_cmp++;
        for (int i = 0; i < 32; i++) if (act[i] === 1'b1) one = 1'b1;
        if (one) begin
            n_bad++;
            $display("FAIL %s: bus driven %h, expected undriven (t=%0t)", name, act, $time);
        end
    endtask

    function automatic logic [32:0] m_read(input logic [31:0] a);
        logic [32:0] r = '0;
        case (a)
            A_DIR:  r = {1'b1, 32'(m_dir)};
            A_OUT:  r = {1'b1, 32'(m_out)};
            A_IN:   r = {1'b1, 32'(m_in)};
            A_SET, A_CLR, A_TGL: r = {1'b1, 32'h0};
            A_RISE: r = {1'b1, 32'(m_re)};
            A_FALL: r = {1'b1, 32'(m_fe)};
            A_STAT: r = {1'b1, 32'(m_status)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Model: IN flips once the pin, seen S edges late, has held the opposite
    // level over the last DW edges.
    initial begin
        for (int k = 0; k < HIST; k++) hist[k] = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_dir = '0; m_out = '0; m_re = '0; m_fe = '0; m_status = '0;
                m_in = '0; m_prev = '0;
                for (int k = 0; k < HIST; k++) hist[k] = '0;
            end else begin
                logic [W-1:0] lvl, rise, fall, w1c, flip;
                logic [W-1:0] wd;
                lvl  = (m_dir & m_out) | (~m_dir & tb_val);
                rise = m_in & ~m_prev & m_re;
                fall = ~m_in & m_prev & m_fe;
                wd   = bus_wdata[W-1:0];
                w1c  = (mode == 2'b10 && addr == A_STAT) ? wd : '0;
                m_status = (m_status & ~w1c) | rise | fall;
                for (int k = HIST - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = lvl;
                for (int i = 0; i < W; i++) begin
                    flip[i] = 1'b1;
                    for (int k = S; k < HIST; k++) if (hist[k][i] == m_in[i]) flip[i] = 1'b0;
                end
                m_prev = m_in;
                m_in   = m_in ^ flip;
                if (mode == 2'b10) begin
                    case (addr)
                        A_DIR:  m_dir = wd;
                        A_OUT:  m_out = wd;
                        A_SET:  m_out = m_out | wd;
                        A_CLR:  m_out = m_out & ~wd;
                        A_TGL:  m_out = m_out ^ wd;
                        A_RISE: m_re  = wd;
                        A_FALL: m_fe  = wd;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    initial begin
        forever begin
            logic [32:0] r;
            @(negedge clk);
            chk("irq", {31'b0, irq}, {31'b0, |m_status});
            chk("pins", 32'(pins), 32'((m_dir & m_out) | (~m_dir & tb_val)));
            if (mode == 2'b01) begin
                r = m_read(addr);
                if (r[32]) chk("bus_rd", bus, r[31:0]);
                else chk_nd("bus_unmapped", bus);
            end else if (mode != 2'b10) begin
                chk_nd("bus_idle", bus);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; bus_wdata = d; bus_en = 1'b1; mode = 2'b10;
        step();
        mode = 2'b00; bus_en = 1'b0;
    endtask

    // Same-cycle combinational read, no clock consumed.
    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; mode = 2'b01;
        #1;
        chk(name, bus, exp);
        mode = 2'b00;
    endtask

    task automatic peek_nd(input string name, input logic [31:0] a);
        addr = a; mode = 2'b01;
        #1;
        chk_nd(name, bus);
        mode = 2'b00;
    endtask

    // Read held across a clock edge so the per-cycle checker sees it too.
    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; mode = 2'b01;
        #1;
        chk(name, bus, exp);
        step();
        mode = 2'b00;
    endtask

    initial begin
        reset = 1'b0; mode = 2'b00; addr = '0;
        #1 reset = 1'b1;
        step(2);
        reset = 1'b0;

        // Defaults
        chk("rst_pins", 32'(pins), 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        rd("rst_dir", A_DIR, 32'h0);
        rd("rst_out", A_OUT, 32'h0);
        #1 chk_nd("idle_bus", bus);
        peek_nd("unmapped_4060", 32'h4060);
        step();

        // Output path
        wr(A_DIR, 32'hFFFF_00FF);
        rd("dir_mask", A_DIR, 32'h0000_00FF);
        wr(A_OUT, 32'h0000_00A5);
        chk("pins_a5", 32'(pins), 32'h0000_00A5);
        wr(A_SET, 32'h0000_0100);
        peek("out_set", A_OUT, 32'h0000_01A5);
        chk("pin8_z", 32'(pins), 32'h0000_00A5);
        wr(A_TGL, 32'h0000_0005);
        peek("out_tgl", A_OUT, 32'h0000_01A0);
        wr(A_CLR, 32'h0000_0080);
        peek("out_clr", A_OUT, 32'h0000_0120);
        wr(BASE + 32'h24, 32'h0000_FFFF);
        peek("out_unmapped_wr", A_OUT, 32'h0000_0120);
        wr(A_IN, 32'h0000_FFFF);
        peek("dir_in_wr", A_DIR, 32'h0000_00FF);
        rd("rd_set", A_SET, 32'h0);
        rd("rd_clr", A_CLR, 32'h0);
        rd("rd_tgl", A_TGL, 32'h0);
        peek_nd("misaligned", BASE + 32'h2);
        step();
        peek_nd("below_base", BASE - 32'h4);
        step(8);
        peek("in_readback", A_IN, 32'h0000_0020);
        wr(A_DIR, 32'h0);
        step(8);
        peek("in_dir0", A_IN, 32'h0);

        // Glitch rejection then held rise
        wr(A_RISE, 32'h0000_0008);
        tb_val[3] = 1'b1;
        step(2);
        tb_val[3] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            peek("glitch_in", A_IN, 32'h0);
        end
        peek("glitch_status", A_STAT, 32'h0);
        tb_val[3] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) peek("lat_early", A_IN, 32'h0);
            if (k == 7) begin
                peek("lat_in", A_IN, 32'h0000_0008);
                chk("lat_irq_early", {31'b0, irq}, 32'h0);
            end
        end
        step();
        peek("rise_status", A_STAT, 32'h0000_0008);
        chk("rise_irq", {31'b0, irq}, 32'h1);

        // Fall with FALL_EN clear sets nothing; then W1C
        tb_val[3] = 1'b0;
        step(10);
        peek("no_fall_bit", A_STAT, 32'h0000_0008);
        wr(A_STAT, 32'h0000_0008);
        chk("w1c_irq", {31'b0, irq}, 32'h0);
        peek("w1c_status", A_STAT, 32'h0);

        // W1C coinciding with a fresh rise: the set wins
        tb_val[3] = 1'b1;
        step(7);
        peek("collide_in", A_IN, 32'h0000_0008);
        wr(A_STAT, 32'h0000_0008);
        peek("collide_status", A_STAT, 32'h0000_0008);
        chk("collide_irq", {31'b0, irq}, 32'h1);

        // Falling-edge capture and stickiness after disable
        wr(A_RISE, 32'h0);
        wr(A_FALL, 32'h0000_0008);
        wr(A_STAT, 32'h0000_0008);
        peek("fall_clr", A_STAT, 32'h0);
        tb_val[3] = 1'b0;
        step(8);
        peek("fall_status", A_STAT, 32'h0000_0008);
        wr(A_FALL, 32'h0);
        peek("sticky_status", A_STAT, 32'h0000_0008);
        chk("sticky_irq", {31'b0, irq}, 32'h1);

        // Reset mid-debounce (pin 3 kept as input so the bench can drive it)
        wr(A_DIR, 32'h0000_FFF7);
        wr(A_OUT, 32'h0000_FFFF);
        chk("pins_all_out", 32'(pins), 32'h0000_FFF7);
        tb_val[3] = 1'b1;
        step(2);
        reset = 1'b1;
        #1;
        chk("midrst_pins", 32'(pins), 32'h0000_0008);
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        peek("midrst_status", A_STAT, 32'h0);
        step();
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) peek("postrst_dir", A_DIR, 32'h0);
            if (k == 6) peek("postrst_early", A_IN, 32'h0);
            if (k == 7) peek("postrst_in", A_IN, 32'h0000_0008);
        end
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
